// File: rtl/mem_arbiter_if.sv
// Bus bundle between the icache/dcache requesters, the arbiter and the memory port.
// The slave modport is the arbiter's view; master is the environment driving it.
interface mem_arbiter_if;
    logic        icache_REN;
    logic [31:0] icache_addr;
    logic        icache_ready;
    logic [31:0] icache_load;

    logic        dcache_REN;
    logic        dcache_WEN;
    logic [31:0] dcache_addr;
    logic [31:0] dcache_store;
    logic        dcache_ready;
    logic [31:0] dcache_load;

    logic        mem_REN;
    logic        mem_WEN;
    logic [31:0] mem_addr;
    logic [31:0] mem_store;
    logic [31:0] mem_load;
    logic        mem_ready;

    logic        arb_busy;

    modport slave (
        input  icache_REN, icache_addr,
        output icache_ready, icache_load,
        input  dcache_REN, dcache_WEN, dcache_addr, dcache_store,
        output dcache_ready, dcache_load,
        output mem_REN, mem_WEN, mem_addr, mem_store,
        input  mem_load, mem_ready,
        output arb_busy
    );

    modport master (
        output icache_REN, icache_addr,
        input  icache_ready, icache_load,
        output dcache_REN, dcache_WEN, dcache_addr, dcache_store,
        input  dcache_ready, dcache_load,
        input  mem_REN, mem_WEN, mem_addr, mem_store,
        output mem_load, mem_ready,
        input  arb_busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: dcache has priority, icache is forced through after
// STARVE_LIMIT consecutive dcache grants made while it was waiting.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic          CLK,
    input  logic          nRST,
    mem_arbiter_if.slave  bus
);

    localparam int              CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        SERVE_I = 2'b01,
        SERVE_D = 2'b10
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_starve_cnt;
    logic [CNT_W-1:0]  w_starve_nxt;
    logic [31:0]       r_addr;
    logic [31:0]       w_addr_nxt;
    logic [31:0]       r_store;
    logic [31:0]       w_store_nxt;
    logic              r_ren;
    logic              w_ren_nxt;
    logic              r_wen;
    logic              w_wen_nxt;
    logic              w_d_req;
    logic              w_grant_i;
    logic              w_grant_d;

    assign w_d_req = bus.dcache_REN | bus.dcache_WEN;

    // Next-state, grant decision and transaction latch contents
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_store_nxt = r_store;
        w_ren_nxt   = r_ren;
        w_wen_nxt   = r_wen;
        w_grant_i   = 1'b0;
        w_grant_d   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_d_req && (!bus.icache_REN || (r_starve_cnt != CNT_MAX))) begin
                    w_grant_d   = 1'b1;
                    w_state_nxt = SERVE_D;
                    w_addr_nxt  = bus.dcache_addr;
                    w_store_nxt = bus.dcache_store;
                    // REN+WEN together is a write
                    w_wen_nxt   = bus.dcache_WEN;
                    w_ren_nxt   = ~bus.dcache_WEN;
                end else if (bus.icache_REN) begin
                    w_grant_i   = 1'b1;
                    w_state_nxt = SERVE_I;
                    w_addr_nxt  = bus.icache_addr;
                    w_store_nxt = 32'h0000_0000;
                    w_wen_nxt   = 1'b0;
                    w_ren_nxt   = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            SERVE_I, SERVE_D: begin
                if (bus.mem_ready) begin
                    w_state_nxt = IDLE;
                    w_addr_nxt  = 32'h0000_0000;
                    w_store_nxt = 32'h0000_0000;
                    w_ren_nxt   = 1'b0;
                    w_wen_nxt   = 1'b0;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_addr_nxt  = 32'h0000_0000;
                w_store_nxt = 32'h0000_0000;
                w_ren_nxt   = 1'b0;
                w_wen_nxt   = 1'b0;
            end
        endcase
    end

    // Starvation counter: counts dcache wins over a waiting icache, saturating
    always_comb begin
        w_starve_nxt = r_starve_cnt;
        if (w_grant_i) begin
            w_starve_nxt = '0;
        end else if (w_grant_d && bus.icache_REN && (r_starve_cnt != CNT_MAX)) begin
            w_starve_nxt = r_starve_cnt + CNT_ONE;
        end else begin
            w_starve_nxt = r_starve_cnt;
        end
    end

    // State, counter and latched transaction registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state      <= IDLE;
            r_starve_cnt <= '0;
            r_addr       <= 32'h0000_0000;
            r_store      <= 32'h0000_0000;
            r_ren        <= 1'b0;
            r_wen        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_starve_cnt <= w_starve_nxt;
            r_addr       <= w_addr_nxt;
            r_store      <= w_store_nxt;
            r_ren        <= w_ren_nxt;
            r_wen        <= w_wen_nxt;
        end
    end

    // Memory side only ever sees the latched copy, so it stays stable per transaction
    assign bus.mem_REN   = r_ren;
    assign bus.mem_WEN   = r_wen;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_store = r_store;

    assign bus.icache_ready = bus.mem_ready & (r_state == SERVE_I);
    assign bus.dcache_ready = bus.mem_ready & (r_state == SERVE_D);
    assign bus.icache_load  = (r_state == SERVE_I) ? bus.mem_load : 32'h0000_0000;
    assign bus.dcache_load  = (r_state == SERVE_D) ? bus.mem_load : 32'h0000_0000;
    assign bus.arb_busy     = (r_state != IDLE);

endmodule
